// File: rtl/corr_autoscale_cast_pkg.sv
// Package: corr_cast_pkg
// Shared constants and helpers for the correlation-to-eigen cast stage.
//   I_OUT / W_TOP / CNT_WIDTH : values for the default 32.16 -> 16.15 cast
//   calc_w_top()              : input bit that lands on the output MSB
//   sat_limit()               : signed max/min pattern for an output width
package corr_cast_pkg;

  localparam int DEF_DIN_WIDTH  = 32;
  localparam int DEF_DIN_POINT  = 16;
  localparam int DEF_DOUT_WIDTH = 16;
  localparam int DEF_DOUT_POINT = 15;

  localparam int I_OUT     = DEF_DOUT_WIDTH - DEF_DOUT_POINT;
  localparam int W_TOP     = DEF_DIN_POINT + I_OUT - 1;
  localparam int CNT_WIDTH = $clog2(DEF_DIN_WIDTH);

  // Bit of the input word that becomes the output sign bit.
  function automatic int calc_w_top(input int din_point, input int dout_width,
                                    input int dout_point);
    return din_point + (dout_width - dout_point) - 1;
  endfunction

  // Most negative (neg=1) or most positive (neg=0) value of a signed
  // 'width'-bit word, in the low bits of the result.
  function automatic logic [63:0] sat_limit(input int width, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/corr_autoscale_cast_sign_lead_count.sv
// Module: sign_lead_count
// Combinational count of redundant sign bits in one signed word: the number
// of bits directly below the MSB that repeat the MSB. 0 and -1 both give
// DIN_WIDTH-1.
//   din : signed input word
//   cnt : redundant sign bit count
module sign_lead_count #(
  parameter int DIN_WIDTH = 32,
  parameter int CNT_WIDTH = $clog2(DIN_WIDTH)
) (
  input  logic [DIN_WIDTH-1:0] din,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = DIN_WIDTH - 2; i >= 0; i--) begin
      if (run && (din[i] == din[DIN_WIDTH-1])) begin
        cnt = cnt + CNT_WIDTH'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/corr_autoscale_cast.sv
// Module: corr_autoscale_cast
// Block-exponent cast of PARALLEL correlation words into the eigen-solver
// input format. One right shift (manual, or the smallest shift that fits
// every channel) is applied to all channels of a sample so ratios survive;
// the result is truncated and saturated to DOUT_WIDTH.DOUT_POINT.
//   clk, rst_n               : clock, async active-low reset
//   din/din_valid/din_ready  : input sample (channel 0 in LSBs)
//   auto_en, shift_manual    : exponent mode / manual shift, taken with din
//   dout/dout_valid/dout_ready : cast sample
//   dout_shift               : shift applied; true value = dout * 2^dout_shift
//   ovf, ovf_clr             : sticky per-channel saturation flags / clear
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high. The three stages S0 (capture), S1 (exponent) and S2 (cast)
// move together on en = ~dout_valid | dout_ready, and din_ready = en, so a
// stalled output holds dout/dout_shift/dout_valid and freezes the pipe.
// Bubbles travel through the pipe and are not squeezed out.
module corr_autoscale_cast
  import corr_cast_pkg::*;
#(
  parameter int PARALLEL    = 4,
  parameter int DIN_WIDTH   = 32,
  parameter int DIN_POINT   = 16,
  parameter int DOUT_WIDTH  = 16,
  parameter int DOUT_POINT  = 15,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PARALLEL*DIN_WIDTH-1:0]  din,
  input  logic                           din_valid,
  output logic                           din_ready,
  input  logic                           auto_en,
  input  logic [SHIFT_WIDTH-1:0]         shift_manual,
  output logic [PARALLEL*DOUT_WIDTH-1:0] dout,
  output logic [SHIFT_WIDTH-1:0]         dout_shift,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [PARALLEL-1:0]            ovf,
  input  logic                           ovf_clr
);

  localparam int TOP_BIT   = calc_w_top(DIN_POINT, DOUT_WIDTH, DOUT_POINT);
  // Extra right shift that drops the fraction bits the output cannot hold.
  localparam int FRAC_DROP = DIN_POINT - DOUT_POINT;
  localparam int CNT_W     = $clog2(DIN_WIDTH);
  localparam int SHIFT_MAX = (1 << SHIFT_WIDTH) - 1;

  logic en;
  assign en        = ~dout_valid | dout_ready;
  assign din_ready = en;

  // ---------------- S0: capture ----------------
  logic                          s0_valid;
  logic                          s0_auto;
  logic [PARALLEL*DIN_WIDTH-1:0] s0_din;
  logic [SHIFT_WIDTH-1:0]        s0_shift_manual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid        <= 1'b0;
      s0_auto         <= 1'b0;
      s0_din          <= '0;
      s0_shift_manual <= '0;
    end else if (en) begin
      s0_valid        <= din_valid;
      s0_auto         <= auto_en;
      s0_din          <= din;
      s0_shift_manual <= shift_manual;
    end
  end

  // ---------------- S1: exponent ----------------
  logic [CNT_W-1:0]       rsb [PARALLEL];
  logic [SHIFT_WIDTH-1:0] shift_auto;
  logic [SHIFT_WIDTH-1:0] shift_next;

  for (genvar k = 0; k < PARALLEL; k++) begin : g_slc
    sign_lead_count #(
      .DIN_WIDTH (DIN_WIDTH),
      .CNT_WIDTH (CNT_W)
    ) u_slc (
      .din (s0_din[k*DIN_WIDTH +: DIN_WIDTH]),
      .cnt (rsb[k])
    );
  end

  // Sign position t_k = DIN_WIDTH-1-r_k; each channel needs t_k-TOP_BIT
  // of right shift for its sign to land on the output MSB.
  always_comb begin
    int need;
    int worst;
    need  = 0;
    worst = 0;
    for (int k = 0; k < PARALLEL; k++) begin
      need = (DIN_WIDTH - 1 - int'(rsb[k])) - TOP_BIT;
      if (need > worst) worst = need;
    end
    if (worst > SHIFT_MAX) worst = SHIFT_MAX;
    shift_auto = SHIFT_WIDTH'(worst);
  end

  assign shift_next = s0_auto ? shift_auto : s0_shift_manual;

  logic                          s1_valid;
  logic [PARALLEL*DIN_WIDTH-1:0] s1_din;
  logic [SHIFT_WIDTH-1:0]        s1_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_din   <= '0;
      s1_shift <= '0;
    end else if (en) begin
      s1_valid <= s0_valid;
      s1_din   <= s0_din;
      s1_shift <= shift_next;
    end
  end

  // ---------------- S2: shift, cast, saturate ----------------
  logic [PARALLEL*DOUT_WIDTH-1:0] cast_data;
  logic [PARALLEL-1:0]            cast_sat;

  // Shifting by s+FRAC_DROP puts the output word in the low DOUT_WIDTH
  // bits; it fits when everything from the output MSB upward is one sign.
  always_comb begin
    logic signed [DIN_WIDTH-1:0] y;
    y         = '0;
    cast_data = '0;
    cast_sat  = '0;
    for (int k = 0; k < PARALLEL; k++) begin
      y = $signed(s1_din[k*DIN_WIDTH +: DIN_WIDTH]) >>> (int'(s1_shift) + FRAC_DROP);
      if ((&y[DIN_WIDTH-1:DOUT_WIDTH-1]) | ~(|y[DIN_WIDTH-1:DOUT_WIDTH-1])) begin
        cast_data[k*DOUT_WIDTH +: DOUT_WIDTH] = y[DOUT_WIDTH-1:0];
      end else begin
        cast_data[k*DOUT_WIDTH +: DOUT_WIDTH] =
          DOUT_WIDTH'(sat_limit(DOUT_WIDTH, y[DIN_WIDTH-1]));
        cast_sat[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_shift <= '0;
    end else if (en) begin
      dout_valid <= s1_valid;
      dout       <= cast_data;
      dout_shift <= s1_shift;
    end
  end

  // A new saturation beats a simultaneous clear on the same channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{PARALLEL{ovf_clr}}) | ((en && s1_valid) ? cast_sat : '0);
    end
  end

endmodule

// File: tb/tb_corr_autoscale_cast.sv
// Bench for corr_autoscale_cast: scoreboard queues filled by the drivers,
// monitors pop and compare whenever a DUT presents an output.
module tb_corr_autoscale_cast;

  localparam int P   = 4;
  localparam int DW  = 32;
  localparam int DP  = 16;
  localparam int OW  = 16;
  localparam int OP  = 15;
  localparam int SW  = 5;
  localparam int SWC = 3;
  // Output sign sits on input bit DP+(OW-OP)-1; a shifted value fits when
  // it lies in [-LIM, LIM-1].
  localparam longint LIM  = longint'(1) << (DP + (OW - OP) - 1);
  localparam int     DROP = DP - OP;

  typedef struct packed {
    logic [P*OW-1:0] d;
    logic [SW-1:0]   s;
    logic [P-1:0]    sat;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic [P*DW-1:0] din = '0;
  logic            din_valid = 1'b0;
  logic            din_ready;
  logic            auto_en = 1'b0;
  logic [SW-1:0]   shift_manual = '0;
  logic [P*OW-1:0] dout;
  logic [SW-1:0]   dout_shift;
  logic            dout_valid;
  logic            dout_ready = 1'b1;
  logic [P-1:0]    ovf;
  logic            ovf_clr = 1'b0;

  // DUT B: 3-bit shift field
  logic [P*DW-1:0] b_din = '0;
  logic            b_din_valid = 1'b0;
  logic            b_din_ready;
  logic            b_auto_en = 1'b0;
  logic [SWC-1:0]  b_shift_manual = '0;
  logic [P*OW-1:0] b_dout;
  logic [SWC-1:0]  b_dout_shift;
  logic            b_dout_valid;
  logic            b_dout_ready = 1'b1;
  logic [P-1:0]    b_ovf;
  logic            b_ovf_clr = 1'b0;

  corr_autoscale_cast #(
    .PARALLEL(P), .DIN_WIDTH(DW), .DIN_POINT(DP),
    .DOUT_WIDTH(OW), .DOUT_POINT(OP), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .auto_en(auto_en), .shift_manual(shift_manual),
    .dout(dout), .dout_shift(dout_shift), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  corr_autoscale_cast #(
    .PARALLEL(P), .DIN_WIDTH(DW), .DIN_POINT(DP),
    .DOUT_WIDTH(OW), .DOUT_POINT(OP), .SHIFT_WIDTH(SWC)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_din_valid),
    .din_ready(b_din_ready), .auto_en(b_auto_en), .shift_manual(b_shift_manual),
    .dout(b_dout), .dout_shift(b_dout_shift), .dout_valid(b_dout_valid),
    .dout_ready(b_dout_ready), .ovf(b_ovf), .ovf_clr(b_ovf_clr)
  );

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  exp_t b_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: actual no event required event within bound", name);
  endtask

  // ---------------- reference model ----------------
  function automatic bit fits(input longint y);
    return (y >= -LIM) && (y <= LIM - 1);
  endfunction

  // Auto: smallest shift (up to smax) after which every channel fits the
  // output range. Then truncate the fraction and saturate what still
  // does not fit.
  function automatic exp_t model(input logic [P*DW-1:0] d, input logic au,
                                 input int sm, input int smax);
    exp_t r;
    longint v[P];
    longint y;
    longint o;
    logic signed [DW-1:0] w;
    int s;
    bit ok;
    r = '0;
    for (int k = 0; k < P; k++) begin
      w = d[k*DW +: DW];
      v[k] = w;
    end
    if (au) begin
      s = smax;
      for (int c = smax; c >= 0; c--) begin
        ok = 1'b1;
        for (int k = 0; k < P; k++) if (!fits(v[k] >>> c)) ok = 1'b0;
        if (ok) s = c;
      end
    end else begin
      s = sm;
    end
    for (int k = 0; k < P; k++) begin
      y = v[k] >>> s;
      if (fits(y)) begin
        o = y >>> DROP;
        r.d[k*OW +: OW] = o[OW-1:0];
      end else begin
        r.d[k*OW +: OW] = (y < 0) ? 16'h8000 : 16'h7FFF;
        r.sat[k] = 1'b1;
      end
    end
    r.s = SW'(s);
    return r;
  endfunction

  function automatic logic [P*DW-1:0] rand_vec();
    logic [P*DW-1:0] v;
    logic signed [DW-1:0] w;
    for (int k = 0; k < P; k++) begin
      w = $urandom;
      w = w >>> $urandom_range(0, 31);
      v[k*DW +: DW] = w;
    end
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [P*DW-1:0] d, input logic au, input logic [SW-1:0] sm);
    int w;
    din = d; auto_en = au; shift_manual = sm; din_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!din_ready && w < 200) begin @(negedge clk); w++; end
    if (!din_ready) fail_now("send_accept");
    else exp_q.push_back(model(d, au, int'(sm), (1 << SW) - 1));
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic send_b(input logic [P*DW-1:0] d, input logic au, input logic [SWC-1:0] sm);
    int w;
    b_din = d; b_auto_en = au; b_shift_manual = sm; b_din_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!b_din_ready && w < 200) begin @(negedge clk); w++; end
    if (!b_din_ready) fail_now("send_b_accept");
    else b_q.push_back(model(d, au, int'(sm), (1 << SWC) - 1));
    @(posedge clk); #1;
    b_din_valid = 1'b0;
  endtask

  // One sample into an idle pipe; counts cycles from acceptance to dout_valid.
  task automatic lat_probe(input logic [P*DW-1:0] d, input logic au, input logic [SW-1:0] sm);
    int n;
    din = d; auto_en = au; shift_manual = sm; din_valid = 1'b1;
    @(negedge clk);
    check("accept_ready", din_ready, 1'b1);
    exp_q.push_back(model(d, au, int'(sm), (1 << SW) - 1));
    @(posedge clk); #1;
    din_valid = 1'b0;
    n = 0;
    while (!dout_valid && n < 10) begin @(negedge clk); n++; end
    check("latency", n, 3);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || b_q.size() != 0) && w < 200) begin @(posedge clk); w++; end
    if (exp_q.size() != 0 || b_q.size() != 0) fail_now("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor A ----------------
  logic         holding = 1'b0;
  logic         prev_clr = 1'b0;
  logic [P-1:0] exp_ovf = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding  = 1'b0;
        prev_clr = 1'b0;
        exp_ovf  = '0;
      end else begin
        check("din_ready", din_ready, !dout_valid || dout_ready);
        exp_ovf = prev_clr ? '0 : exp_ovf;
        if (dout_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            if (!holding) exp_ovf = exp_ovf | exp_q[0].sat;
            check("dout", dout, exp_q[0].d);
            check("dout_shift", dout_shift, exp_q[0].s);
            if (dout_ready) void'(exp_q.pop_front());
          end
        end
        check("ovf", ovf, exp_ovf);
        holding  = dout_valid && !dout_ready;
        prev_clr = ovf_clr;
      end
    end
  end

  // ---------------- monitor B ----------------
  logic [P-1:0] b_exp_ovf = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_exp_ovf = '0;
      end else if (b_dout_valid) begin
        if (b_q.size() == 0) begin
          fail_now("b_unexpected_output");
        end else begin
          e = b_q.pop_front();
          b_exp_ovf = b_exp_ovf | e.sat;
          check("b_dout", b_dout, e.d);
          check("b_dout_shift", b_dout_shift, e.s[SWC-1:0]);
          check("b_ovf", b_ovf, b_exp_ovf);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    fail_now("watchdog");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit done;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout", dout, '0);
    check("rst_dout_shift", dout_shift, '0);
    check("rst_ovf", ovf, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_din_ready", din_ready, 1'b1);

    // 0.5 on ch0, auto: latency 3, 0x4000, shift 0
    lat_probe({32'h0, 32'h0, 32'h0, 32'h0000_8000}, 1'b1, '0);
    drain();

    // block exponent: 1.0, 0.25, -1.0, 0 -> shift 1
    send({32'h0, 32'hFFFF_0000, 32'h0000_4000, 32'h0001_0000}, 1'b1, '0);
    drain();

    // manual saturation, flag is sticky while idle
    send({32'h0, 32'h0, 32'hFFFC_0000, 32'h0004_0000}, 1'b0, 5'd0);
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("ovf_sticky", ovf, 4'b0011);

    // clear coincides with a new ch0 saturation entering the output stage
    send({32'h0, 32'h0, 32'h0, 32'h0004_0000}, 1'b0, 5'd0);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_set_wins", ovf, 4'b0001);
    drain();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(posedge clk); #1;
    check("ovf_cleared", ovf, 4'b0000);

    // backpressure: 8 back-to-back samples, output stalled for 4 cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_vec(), 1'($urandom_range(0, 1)), SW'($urandom_range(0, 20)));
      end
      begin
        repeat (4) @(posedge clk);
        #1 dout_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 dout_ready = 1'b1;
      end
    join
    drain();

    // reset with three samples in flight
    for (int i = 0; i < 3; i++) send(rand_vec(), 1'b1, '0);
    check("pre_reset_valid", dout_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", dout_valid, 1'b0);
    check("async_rst_dout", dout, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    lat_probe({32'h0, 32'h0, 32'h0, 32'h0001_0000}, 1'b1, '0);
    drain();

    // shift clamp on the 3-bit-shift instance, then a few random samples
    send_b({32'h0, 32'h0, 32'h0, 32'h4000_0000}, 1'b1, '0);
    for (int i = 0; i < 6; i++) send_b(rand_vec(), 1'($urandom_range(0, 1)), SWC'($urandom_range(0, 7)));
    drain();
    check("b_clamp_ovf", b_ovf[0], 1'b1);

    // random traffic with random backpressure, gaps and clears
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ovf_clr = ($urandom_range(0, 9) == 0);
          send(rand_vec(), 1'($urandom_range(0, 1)), SW'($urandom_range(0, 31)));
          ovf_clr = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          dout_ready = ($urandom_range(0, 3) != 0);
        end
        dout_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/corr_autoscale_cast.md
Name: corr_autoscale_cast

Overview:
- Parametrised successor to the fixed-shift correlation-to-eigen cast stage. Sits between the correlation-matrix accumulator and the eigen solver.
- Takes PARALLEL correlation words per sample and applies one shift to all of them. The shift is either manual or auto-computed per sample as a block exponent, so eigen ratios are preserved.
- Casts the result to the linear-algebra input format with saturation. Reports the applied shift and sticky per-channel overflow flags.
- Adds a valid/ready handshake, so a busy eigen stage can stall the path.

Parameters:
- PARALLEL, 4, number of channels sharing one exponent (r11, r22, r12_re, r12_im).
- DIN_WIDTH, 32, input word width (signed).
- DIN_POINT, 16, input fractional bits.
- DOUT_WIDTH, 16, output word width (signed).
- DOUT_POINT, 15, output fractional bits.
- SHIFT_WIDTH, 5, width of the shift/exponent field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- din  in  PARALLEL*DIN_WIDTH  packed channels; channel 0 occupies the LSBs.
- din_valid  in  1  input qualifier.
- din_ready  out  1  block can accept din this cycle.
- auto_en  in  1  1 = auto exponent, 0 = use shift_manual.
- shift_manual  in  SHIFT_WIDTH  right shift used when auto_en=0; sampled with din.
- dout  out  PARALLEL*DOUT_WIDTH  cast channels.
- dout_shift  out  SHIFT_WIDTH  shift applied to this dout.
- dout_valid  out  1  output qualifier.
- dout_ready  in  1  downstream accepts.
- ovf  out  PARALLEL  sticky per-channel saturation flags.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async assert, sync release): all pipeline valids = 0, dout = 0, dout_shift = 0, ovf = 0. In-flight samples are discarded. din_ready = 1 after reset.
- Pipeline, three registered stages:
  - S0 captures din, auto_en and shift_manual.
  - S1 computes per-channel redundant-sign-bit count r_k and the shift s.
  - S2 performs the shift, cast and saturation, and drives dout.
- Latency is 3 cycles from an accepted din to dout_valid when there is no stall.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - Global enable en = ~dout_valid | dout_ready. All stages advance only when en = 1; din_ready = en.
  - While stalled, dout, dout_shift and dout_valid hold stable.
  - Bubbles are not compressed. Throughput is 1 sample/cycle with dout_ready held high.
- Exponent computation:
  - I_OUT = DOUT_WIDTH-DOUT_POINT; W_TOP = DIN_POINT+I_OUT-1.
  - Sign position t_k = DIN_WIDTH-1-r_k. For value 0, r_k = DIN_WIDTH-1.
  - Auto mode: s = max over k of max(0, t_k-W_TOP), clamped to 2^SHIFT_WIDTH-1.
  - Manual mode: s = shift_manual.
- Cast: y_k = (din_k >>> s), then take bits [W_TOP -: DOUT_WIDTH].
  - Arithmetic shift; truncation toward -inf; no rounding.
  - If y_k's bits above W_TOP are not all equal to the sign, saturate to 0x7FF..F or 0x800..0 and set ovf[k].
  - In auto mode saturation occurs only when s was clamped.
- ovf:
  - Set on the S2 transfer cycle.
  - ovf_clr clears all bits.
  - If set and ovf_clr occur in the same cycle, set wins for that channel.
- dout_shift = s for the corresponding sample. The true value equals dout * 2^dout_shift.

Decomposition:
- Package corr_cast_pkg holds:
  - localparams I_OUT and W_TOP;
  - CNT_WIDTH = $clog2(DIN_WIDTH);
  - a saturating-limit function returning max/min for DOUT_WIDTH.
- One sub-module, sign_lead_count: combinational count of redundant sign bits for one DIN_WIDTH word, instantiated PARALLEL times in S1.
- Top level holds the stage registers, the max-reduction, the shifters and the handshake.

Test Plan:
- Reset/latency: auto_en=1, ch0=0x0000_8000 (0.5), others 0, dout_ready=1.
  - dout_valid rises 3 cycles after acceptance.
  - ch0 = 0x4000, dout_shift = 0, ovf = 0.
- Block exponent: auto_en=1, ch0=0x0001_0000 (1.0), ch1=0x0000_4000 (0.25), ch2=0xFFFF_0000 (-1.0), ch3=0.
  - dout_shift = 1.
  - dout ch0=0x4000, ch1=0x1000, ch2=0xC000, ch3=0x0000; no ovf.
- Manual saturation: auto_en=0, shift_manual=0, ch0=0x0004_0000 (4.0), ch1=0xFFFC_0000 (-4.0).
  - ch0=0x7FFF, ch1=0x8000, ovf=4'b0011.
  - ovf stays set until ovf_clr is pulsed.
  - Pulse ovf_clr on the same cycle as a new saturating sample: the flag remains 1.
- Backpressure: stream 8 samples back-to-back, hold dout_ready=0 for cycles 4-7.
  - din_ready = 0 while dout_valid & ~dout_ready.
  - dout holds stable; all 8 samples emerge in order with none lost or duplicated.
- Reset mid-operation: assert rst_n=0 with 3 samples in flight.
  - dout_valid=0 and dout=0 immediately (async).
  - After release, no stale sample appears; the next accepted sample has latency 3.
- Shift clamp: SHIFT_WIDTH=3, auto_en=1, ch0=0x4000_0000.
  - Required shift is 15; it is clamped to 7, so dout_shift = 7.
  - ch0 = 0x7FFF and ovf[0] = 1.
